pclk_div_gen: RTL
=================

Name: pclk_div_gen

Overview:
- Parametrised successor to the PHY common clock block: derives the symbol clock and PCLK from the bit-rate clock using registered counter dividers.
- Adds programmable symbol ratio and glitch-free PCLK ratio switching at period boundaries when DataBusWidth changes.
- Adds an enable input, a settle/ready indication and illegal-width flagging.
- Sits between the PLL bit-rate clock output and the PIPE MAC/PCS clock consumers.

Parameters:
- SYM_RATIO, 10, bit clocks per symbol (8b/10b); legal range 2..63.
- CNT_W, 8, width of the ratio and counter registers; must hold SYM_RATIO*4.
- SETTLE_PERIODS, 4, number of complete PCLK periods after a ratio is applied before Clk_Ready asserts; legal range 1..15.

Ports:
- Ref_Clk  in  1  bit-rate clock (PLL output); the only clock.
- Rst_n  in  1  asynchronous active-low reset.
- Div_En  in  1  divider enable; low = stop and park.
- DataBusWidth  in  6  PIPE data width: 8, 16 or 32.
- Sym_Clk  out  1  Ref_Clk divided by SYM_RATIO.
- PCLK  out  1  Ref_Clk divided by SYM_RATIO*(DataBusWidth/8).
- Ratio_Cur  out  CNT_W  PCLK ratio currently in effect.
- Clk_Ready  out  1  PCLK stable at Ratio_Cur.
- Ratio_Err  out  1  DataBusWidth is illegal.

Behaviour:
- **Reset values:**
  - Sym_Clk=0, PCLK=0, Clk_Ready=0, Ratio_Err=0.
  - Ratio_Cur=SYM_RATIO; both counters = ratio-1; settle counter = 0.
- **Decode (combinational):**
  - mult = 1, 2 or 4 for DataBusWidth = 8, 16 or 32.
  - Any other value: mult=1.
  - Ratio_Err is registered: on every edge it is set to 1 if the width is illegal, else 0.
  - target = SYM_RATIO*mult.
- **Divider rule (both outputs), per Ref_Clk edge:**
  - cnt_n = (cnt==R-1) ? 0 : cnt+1.
  - clk_n = (cnt_n < HI), where HI = R - R/2 (ceiling half).
  - Outputs are flops only, so no glitches.
  - The high phase starts on the wrap edge (cnt_n==0). Odd R gives a high phase one cycle longer than the low phase.
- **Sym_Clk:** R = SYM_RATIO, fixed.
- **PCLK ratio switching:**
  - R = Ratio_Cur.
  - On a wrap edge (cnt==Ratio_Cur-1), Ratio_Cur <= target. That edge is the first cycle of the new period.
  - Width changes mid-period are ignored until the next wrap. Only the value present at the wrap edge is applied; intermediate values are lost.
  - After reset the first edge is a wrap, so a non-x1 width applies immediately.
- **Settle:**
  - A wrap edge that changes Ratio_Cur, or the first wrap after reset or enable, clears Clk_Ready and sets the settle count to 1.
  - Each later wrap increments the count.
  - Clk_Ready rises on the edge at which the count reaches SETTLE_PERIODS+1, i.e. after SETTLE_PERIODS complete periods; the count then saturates.
  - A new ratio change during settling restarts the count.
- **Div_En low (sampled each edge):**
  - Both counters load R-1, Sym_Clk=PCLK=0, Clk_Ready=0, settle count=0.
  - Ratio_Cur holds its value.
  - When Div_En rises, operation resumes exactly as after reset from the next edge; the first edge is a wrap.
- **Reset mid-operation:** asynchronous return to the reset values; no partial period is emitted.

Optional Feature:
- Macro: PCLK_GATE_EN.
- When defined: PCLK = registered divider output AND Clk_Ready. PCLK stays low during settle, and the cycle that drops Clk_Ready also forces PCLK low.
- When undefined: PCLK toggles throughout settling; Clk_Ready is advisory only.

Decomposition:
- Package pclk_gen_pkg holds:
  - legal width constants W8=8, W16=16, W32=32;
  - the function dbw_to_mult(DataBusWidth) returning 1, 2 or 4 plus an illegal flag;
  - the default CNT_W.
- Sub-module clk_div_core (Ref_Clk, Rst_n, en, ratio_in, clk_out, wrap, ratio_cur):
  - one counter, boundary ratio load, registered output;
  - instantiated twice, with ratio_in tied to SYM_RATIO for Sym_Clk.
- Settle logic, Ratio_Err and gating live in the top module.

Test Plan:
- Reset release, DataBusWidth=8, defaults -> Sym_Clk and PCLK have period 10, high 5 cycles; Ratio_Cur=10; Clk_Ready rises at edge 41 (wraps at edges 1, 11, 21, 31, 41).
- DataBusWidth 8->16 at PCLK counter=3 -> current 10-cycle period completes; then period 20, high 10; Ratio_Cur=20; Clk_Ready falls at the apply edge and rises 80 edges later; Sym_Clk is unaffected.
- DataBusWidth 8->32->8 within one period -> no ratio change, Clk_Ready stays 1; 8->32 held across a wrap -> period 40, Ratio_Cur=40.
- DataBusWidth=12 -> Ratio_Err=1 next edge, PCLK ratio 10; return to 16 -> Ratio_Err=0, ratio 20 applied at next wrap.
- Div_En low for 7 cycles mid-period -> outputs low, Clk_Ready=0; re-enable -> PCLK high on first edge, full period, Clk_Ready after SETTLE_PERIODS periods.
- SYM_RATIO=5, Rst_n asserted mid-high phase -> PCLK/Sym_Clk drop asynchronously to 0; after release Sym_Clk high 3, low 2; with PCLK_GATE_EN, PCLK held low until Clk_Ready.

Source files
------------

// File: rtl/pclk_gen_pkg.sv
// Shared constants and DataBusWidth decode for the PIPE clock divider block.
package pclk_gen_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [5:0] W8  = 6'd8;
  localparam logic [5:0] W16 = 6'd16;
  localparam logic [5:0] W32 = 6'd32;

  typedef struct packed {
    logic [2:0] mult;
    logic       illegal;
  } dbw_dec_t;

  // Illegal widths fall back to x1 so PCLK keeps running at the symbol rate.
  function automatic dbw_dec_t dbw_to_mult(input logic [5:0] dbw);
    dbw_dec_t d;
    d.mult    = 3'd1;
    d.illegal = 1'b0;
    case (dbw)
      W8:      d.mult = 3'd1;
      W16:     d.mult = 3'd2;
      W32:     d.mult = 3'd4;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Registered counter divider; a new ratio is taken only on the wrap edge so
// every emitted period is whole and the output never glitches.
module clk_div_core
  import pclk_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int RESET_RATIO = 10
) (
  input  logic             Ref_Clk,
  input  logic             Rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] ratio_in,
  output logic             clk_out,
  output logic             wrap,
  output logic [CNT_W-1:0] ratio_cur
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] hi;

  assign wrap  = en && (cnt == ratio_cur - ONE);
  assign cnt_n = wrap ? '0 : cnt + ONE;
  // Ceiling half: odd ratios get the extra cycle in the high phase.
  assign hi    = ratio_cur - (ratio_cur >> 1);

  always_ff @(posedge Ref_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ratio_cur <= CNT_W'(RESET_RATIO);
      cnt       <= CNT_W'(RESET_RATIO - 1);
      clk_out   <= 1'b0;
    end else if (!en) begin
      cnt     <= ratio_cur - ONE;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      clk_out <= (cnt_n < hi);
      if (wrap) ratio_cur <= ratio_in;
    end
  end

endmodule

// File: rtl/pclk_div_gen.sv
// Symbol clock and PCLK generation from the bit-rate clock with settle tracking.
// Build option PCLK_GATE_EN: gate PCLK with Clk_Ready so it stays low while settling.
module pclk_div_gen
  import pclk_gen_pkg::*;
#(
  parameter int SYM_RATIO      = 10,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int SETTLE_PERIODS = 4
) (
  input  logic             Ref_Clk,
  input  logic             Rst_n,
  input  logic             Div_En,
  input  logic [5:0]       DataBusWidth,
  output logic             Sym_Clk,
  output logic             PCLK,
  output logic [CNT_W-1:0] Ratio_Cur,
  output logic             Clk_Ready,
  output logic             Ratio_Err
);

  localparam int               SET_W       = 5;
  localparam logic [SET_W-1:0] SETTLE_DONE = SET_W'(SETTLE_PERIODS + 1);

  dbw_dec_t         dec;
  logic [CNT_W-1:0] target;
  logic             pclk_raw;
  logic             pclk_wrap;
  logic             sym_wrap_unused;
  logic [CNT_W-1:0] sym_ratio_unused;
  logic [SET_W-1:0] settle_cnt;

  assign dec    = dbw_to_mult(DataBusWidth);
  assign target = CNT_W'(SYM_RATIO * int'(dec.mult));

  clk_div_core #(.CNT_W(CNT_W), .RESET_RATIO(SYM_RATIO)) u_sym_div (
    .Ref_Clk   (Ref_Clk),
    .Rst_n     (Rst_n),
    .en        (Div_En),
    .ratio_in  (CNT_W'(SYM_RATIO)),
    .clk_out   (Sym_Clk),
    .wrap      (sym_wrap_unused),
    .ratio_cur (sym_ratio_unused)
  );

  clk_div_core #(.CNT_W(CNT_W), .RESET_RATIO(SYM_RATIO)) u_pclk_div (
    .Ref_Clk   (Ref_Clk),
    .Rst_n     (Rst_n),
    .en        (Div_En),
    .ratio_in  (target),
    .clk_out   (pclk_raw),
    .wrap      (pclk_wrap),
    .ratio_cur (Ratio_Cur)
  );

  // settle_cnt==0 marks the first wrap after reset or re-enable.
  always_ff @(posedge Ref_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      settle_cnt <= '0;
      Clk_Ready  <= 1'b0;
      Ratio_Err  <= 1'b0;
    end else begin
      Ratio_Err <= dec.illegal;
      if (!Div_En) begin
        settle_cnt <= '0;
        Clk_Ready  <= 1'b0;
      end else if (pclk_wrap) begin
        if ((target != Ratio_Cur) || (settle_cnt == '0)) begin
          settle_cnt <= SET_W'(1);
          Clk_Ready  <= 1'b0;
        end else if (settle_cnt != SETTLE_DONE) begin
          settle_cnt <= settle_cnt + SET_W'(1);
          Clk_Ready  <= ((settle_cnt + SET_W'(1)) == SETTLE_DONE);
        end
      end
    end
  end

`ifdef PCLK_GATE_EN
  assign PCLK = pclk_raw & Clk_Ready;
`else
  assign PCLK = pclk_raw;
`endif

endmodule
